pe_flit_receiver: RTL
=====================

// Module: pe_flit_receiver
// PURPOSE
//  Receive-side endpoint of the PE/NoC port: accepts flits {valid,tail,dest,vc,data} from the router,
//  buffers them in per-VC FIFOs, presents them packet-atomically to a local consumer (valid/ready),
//  and returns one credit {valid,vc} to the router per dequeued flit. Pairs with the PE sender's credit counter.
// PARAMETERS
//  NUM_VCS           2   virtual channels; VC_BITS = (NUM_VCS>1) ? $clog2(NUM_VCS) : 1
//  FLIT_DATA_WIDTH   32  flit payload width
//  NUM_RECV_PORTS    16  endpoints; DEST_BITS = $clog2(NUM_RECV_PORTS)
//  BUF_DEPTH         4   flits per VC FIFO; equals the credits the sender starts with
//  FLIT_W = 2+DEST_BITS+VC_BITS+FLIT_DATA_WIDTH; CREDIT_W = 1+VC_BITS
// PORTS
//  clk             in   1          clock
//  rst_n           in   1          reset, asynchronous, active-low
//  en              in   1          block enable; 0 = freeze
//  recvPortID      in   DEST_BITS  this endpoint's ID
//  flit_in         in   FLIT_W     {valid[MSB],tail,dest,vc,data[LSBs]}
//  en_receiveFlit  out  1          =en (registered), tells the router the port is live
//  credit_out      out  CREDIT_W   {valid,vc} returned credit
//  sendCredit      out  1          credit_out valid strobe
//  out_valid       out  1          head flit of granted VC available
//  out_ready       in   1          consumer accepts
//  out_data        out  FLIT_DATA_WIDTH  payload of presented flit
//  out_vc          out  VC_BITS    VC of presented flit
//  out_tail        out  1          presented flit is last of packet
//  overflow_err    out  1          sticky: flit arrived for a full VC
//  misroute_err    out  1          sticky: accepted flit had dest != recvPortID
// BEHAVIOUR
//  Reset: all FIFOs empty, pointers/counts 0, RR pointer 0, state UNLOCKED; every output 0.
//  Enqueue: when en && flit_in[MSB], flit stored in FIFO[vc] at that posedge. Occupancy is checked
//   before any same-cycle dequeue: full -> flit dropped, overflow_err set (protocol violation).
//   Misrouted flits are still stored; misroute_err set.
//  Presentation: out_* are combinational from the head of the granted VC; a flit enqueued at edge N
//   is visible on out_* after edge N (1-cycle latency). Dequeue = en && out_valid && out_ready.
//  Arbiter FSM: UNLOCKED -> grant = first non-empty VC in round-robin order starting at RR pointer;
//   out_valid=1 iff any VC non-empty. Dequeue of non-tail -> LOCKED(vc). In LOCKED, grant fixed to
//   vc; out_valid=1 only if that FIFO is non-empty (other VCs never interleave). Dequeue of tail ->
//   UNLOCKED, RR pointer = vc+1 mod NUM_VCS. Single-flit packet (tail=1) never locks.
//  Credit: each dequeue yields sendCredit=1, credit_out={1'b1,vc} on the next cycle (registered),
//   otherwise sendCredit=0, credit_out=0. Max one credit/cycle (one dequeue/cycle).
//  Simultaneous enq+deq on same VC: both happen; count unchanged. Enq into empty granted VC while
//   LOCKED: visible next cycle. Pointer wrap at BUF_DEPTH; count width $clog2(BUF_DEPTH+1).
//  en=0: no enqueue, no dequeue, out_valid=0, sendCredit=0, credit_out=0, en_receiveFlit=0 next edge;
//   FIFO contents, FSM, RR pointer, error flags held.
//  Reset mid-packet: contents discarded, FSM UNLOCKED; router/sender must be reset together.
// TESTING
//  1 Reset, en=1; flit vc0 tail=1 data=0xA5 dest=ID -> out_valid next cycle, out_data=0xA5; with
//    out_ready=1, credit_out={1,0} sendCredit=1 exactly one cycle later.
//  2 3-flit packet on vc1 (tail on 3rd) interleaved with 1-flit packet vc0 arriving mid-packet ->
//    out order vc1,vc1,vc1,vc0; no vc0 flit while LOCKED.
//  3 Fill vc0 with 4 flits, out_ready=0, send 5th on vc0 -> overflow_err=1, 5th dropped; drain ->
//    exactly 4 flits, 4 credits.
//  4 Both VCs hold single-flit packets, out_ready=1 continuously -> grants alternate vc0,vc1,vc0,...
//  5 Flit dest=ID+1 -> misroute_err=1, flit still delivered; en=0 for 3 cycles with data queued ->
//    out_valid=0, no credits, contents retained and delivered after en=1.
//  6 Assert rst_n low mid-packet (LOCKED, vc1 non-empty) -> all outputs 0 immediately, empty after release.

Source files
------------

// File: rtl/pe_flit_receiver.sv
// ============================================================================
// pe_flit_receiver : per-VC flit buffering, packet-atomic delivery, credit return
// Rev 1.0
// ============================================================================
`default_nettype none

module pe_flit_receiver #(
  parameter  int NUM_VCS         = 2,
  parameter  int FLIT_DATA_WIDTH = 32,
  parameter  int NUM_RECV_PORTS  = 16,
  parameter  int BUF_DEPTH       = 4,
  localparam int VC_BITS         = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  localparam int DEST_BITS       = $clog2(NUM_RECV_PORTS),
  localparam int FLIT_W          = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH,
  localparam int CREDIT_W        = 1 + VC_BITS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [DEST_BITS-1:0]       recvPortID,
  input  logic [FLIT_W-1:0]          flit_in,
  output logic                       en_receiveFlit,
  output logic [CREDIT_W-1:0]        credit_out,
  output logic                       sendCredit,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FLIT_DATA_WIDTH-1:0] out_data,
  output logic [VC_BITS-1:0]         out_vc,
  output logic                       out_tail,
  output logic                       overflow_err,
  output logic                       misroute_err
);

  localparam int PTR_BITS = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_BITS = $clog2(BUF_DEPTH + 1);
  localparam int ENTRY_W  = FLIT_DATA_WIDTH + 1;

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  logic                       in_valid;
  logic                       in_tail;
  logic [DEST_BITS-1:0]       in_dest;
  logic [VC_BITS-1:0]         in_vc;
  logic [FLIT_DATA_WIDTH-1:0] in_data;

  assign in_valid = flit_in[FLIT_W-1];
  assign in_tail  = flit_in[FLIT_W-2];
  assign in_dest  = flit_in[FLIT_DATA_WIDTH+VC_BITS +: DEST_BITS];
  assign in_vc    = flit_in[FLIT_DATA_WIDTH +: VC_BITS];
  assign in_data  = flit_in[FLIT_DATA_WIDTH-1:0];

  logic [ENTRY_W-1:0]  mem_q    [NUM_VCS][BUF_DEPTH];
  logic [ENTRY_W-1:0]  mem_d    [NUM_VCS][BUF_DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q [NUM_VCS];
  logic [PTR_BITS-1:0] wr_ptr_d [NUM_VCS];
  logic [PTR_BITS-1:0] rd_ptr_q [NUM_VCS];
  logic [PTR_BITS-1:0] rd_ptr_d [NUM_VCS];
  logic [CNT_BITS-1:0] count_q  [NUM_VCS];
  logic [CNT_BITS-1:0] count_d  [NUM_VCS];
  logic [NUM_VCS-1:0]  nonempty;

  logic [0:0]          state_q, state_d;
  logic [VC_BITS-1:0]  lock_vc_q, lock_vc_d;
  logic [VC_BITS-1:0]  rr_q, rr_d;
  logic                overflow_q, overflow_d;
  logic                misroute_q, misroute_d;
  logic                send_credit_q, send_credit_d;
  logic [VC_BITS-1:0]  credit_vc_q, credit_vc_d;
  logic                en_rf_q, en_rf_d;

  logic [VC_BITS-1:0]  grant;
  logic                any_ready;
  logic                valid_int;
  logic                deq;
  logic                enq;
  logic                in_full;
  logic                enq_ok;
  logic [ENTRY_W-1:0]  head;

  function automatic logic [PTR_BITS-1:0] next_ptr(input logic [PTR_BITS-1:0] p);
    return (p == PTR_BITS'(BUF_DEPTH - 1)) ? '0 : p + PTR_BITS'(1);
  endfunction

  function automatic logic [VC_BITS-1:0] next_vc(input logic [VC_BITS-1:0] v);
    return (v == VC_BITS'(NUM_VCS - 1)) ? '0 : v + VC_BITS'(1);
  endfunction

  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) begin
      nonempty[v] = (count_q[v] != '0);
    end
  end

  // Occupancy is judged before any same-cycle dequeue, so a full VC drops the flit.
  assign in_full = (count_q[in_vc] == CNT_BITS'(BUF_DEPTH));
  assign enq     = en && in_valid;
  assign enq_ok  = enq && !in_full;
  assign deq     = valid_int && out_ready;
  assign head    = mem_q[grant][rd_ptr_q[grant]];

  // ---- arbiter FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_UNLOCKED;
      lock_vc_q <= '0;
      rr_q      <= '0;
    end else begin
      state_q   <= state_d;
      lock_vc_q <= lock_vc_d;
      rr_q      <= rr_d;
    end
  end

  // ---- arbiter FSM: next state ----
  always_comb begin
    state_d   = state_q;
    lock_vc_d = lock_vc_q;
    rr_d      = rr_q;
    if (deq) begin
      if (head[ENTRY_W-1]) begin
        state_d = ST_UNLOCKED;
        rr_d    = next_vc(grant);
      end else begin
        state_d   = ST_LOCKED;
        lock_vc_d = grant;
      end
    end
  end

  // ---- arbiter FSM: outputs (grant selection) ----
  always_comb begin
    int idx;
    idx       = 0;
    grant     = lock_vc_q;
    any_ready = 1'b0;
    if (state_q == ST_LOCKED) begin
      any_ready = nonempty[lock_vc_q];
    end else begin
      grant = rr_q;
      // Scan downwards so the lowest round-robin offset wins.
      for (int k = NUM_VCS - 1; k >= 0; k--) begin
        idx = (int'(rr_q) + k) % NUM_VCS;
        if (nonempty[idx]) begin
          grant     = VC_BITS'(idx);
          any_ready = 1'b1;
        end
      end
    end
    valid_int = en && any_ready;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (enq_ok && (in_vc == VC_BITS'(v))) begin
        mem_d[v][wr_ptr_q[v]] = {in_tail, in_data};
        wr_ptr_d[v]           = next_ptr(wr_ptr_q[v]);
      end
      if (deq && (grant == VC_BITS'(v))) begin
        rd_ptr_d[v] = next_ptr(rd_ptr_q[v]);
      end
      count_d[v] = count_q[v]
                 + CNT_BITS'(enq_ok && (in_vc == VC_BITS'(v)))
                 - CNT_BITS'(deq && (grant == VC_BITS'(v)));
    end
  end

  always_comb begin
    overflow_d    = overflow_q | (enq && in_full);
    misroute_d    = misroute_q | (enq_ok && (in_dest != recvPortID));
    send_credit_d = deq;
    credit_vc_d   = deq ? grant : '0;
    en_rf_d       = en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        count_q[v]  <= '0;
      end
      overflow_q    <= 1'b0;
      misroute_q    <= 1'b0;
      send_credit_q <= 1'b0;
      credit_vc_q   <= '0;
      en_rf_q       <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      misroute_q    <= misroute_d;
      send_credit_q <= send_credit_d;
      credit_vc_q   <= credit_vc_d;
      en_rf_q       <= en_rf_d;
    end
  end

  // Storage needs no reset: outputs are masked whenever nothing is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_valid      = valid_int;
  assign out_data       = valid_int ? head[FLIT_DATA_WIDTH-1:0] : '0;
  assign out_tail       = valid_int & head[ENTRY_W-1];
  assign out_vc         = valid_int ? grant : '0;
  assign sendCredit     = send_credit_q;
  assign credit_out     = {send_credit_q, credit_vc_q};
  assign en_receiveFlit = en_rf_q;
  assign overflow_err   = overflow_q;
  assign misroute_err   = misroute_q;

endmodule

`default_nettype wire
